// File: rtl/pipe_ctrl_if.sv
// Hazard-input / pipeline-control bundle between the Y86-64 datapath and pipe_ctrl.
// master drives the stage fields and observes the controls; slave is the controller.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [3:0]       d_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       e_icode;
    logic [3:0]       e_dstM;
    logic             e_cond;
    logic             m_hlt;
    logic             m_in_mem;
    logic             m_in_inst;
    logic             w_hlt;
    logic             w_in_mem;
    logic             w_in_inst;

    logic             f_stall;
    logic             d_stall;
    logic             d_bubble;
    logic             e_bubble;
    logic             m_bubble;
    logic             w_stall;
    logic [2:0]       status;
    logic             halted;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] bub_cnt;
    logic [CNT_W-1:0] ret_cnt_perf;

    modport master (
        output d_icode, d_srcA, d_srcB, e_icode, e_dstM, e_cond,
        output m_hlt, m_in_mem, m_in_inst, w_hlt, w_in_mem, w_in_inst,
        input  f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall,
        input  status, halted, cyc_cnt, bub_cnt, ret_cnt_perf
    );

    modport slave (
        input  d_icode, d_srcA, d_srcB, e_icode, e_dstM, e_cond,
        input  m_hlt, m_in_mem, m_in_inst, w_hlt, w_in_mem, w_in_inst,
        output f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall,
        output status, halted, cyc_cnt, bub_cnt, ret_cnt_perf
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86-64 five-stage hazard controller: load-use / mispredict / ret stall-bubble logic,
// exception drain-and-stop FSM with architectural status, and performance counters.
module pipe_ctrl #(
    parameter int RET_BUBBLES = 3,
    parameter int CNT_W       = 32
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_STOP  = 2'd2
    } state_t;

    localparam logic [2:0] RET_LOAD = 3'(RET_BUBBLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_status;
    logic [2:0]       r_ret_cnt;
    logic [2:0]       r_bub_hist;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_bub_cnt;
    logic [CNT_W-1:0] r_ret_perf;

    logic w_load_use;
    logic w_mispred;
    logic w_ret_d;
    logic w_ret_busy;
    logic w_m_exc;
    logic w_w_exc;
    logic w_f_stall;
    logic w_d_stall;
    logic w_d_bubble;
    logic w_e_bubble;
    logic w_m_bubble;
    logic w_w_stall;

    function automatic logic [2:0] exc_status(input logic hlt, input logic in_mem,
                                              input logic in_inst);
        if (hlt) begin
            return 3'd2;
        end else if (in_mem) begin
            return 3'd3;
        end else if (in_inst) begin
            return 3'd4;
        end else begin
            return 3'd1;
        end
    endfunction

    assign w_load_use = ((bus.e_icode == 4'h5) || (bus.e_icode == 4'hB)) &&
                        (bus.e_dstM != 4'hF) &&
                        ((bus.e_dstM == bus.d_srcA) || (bus.e_dstM == bus.d_srcB));
    assign w_mispred  = (bus.e_icode == 4'h7) && !bus.e_cond;
    assign w_ret_d    = (bus.d_icode == 4'h9);
    // A ret squashed by a mispredict never occupies fetch.
    assign w_ret_busy = (w_ret_d && !w_mispred) || (r_ret_cnt != 3'd0);
    assign w_m_exc    = bus.m_hlt | bus.m_in_mem | bus.m_in_inst;
    assign w_w_exc    = bus.w_hlt | bus.w_in_mem | bus.w_in_inst;

    // Next-state and per-cycle stall/bubble controls; all controls held low during reset.
    always_comb begin
        w_state_nxt = r_state;
        w_f_stall   = 1'b0;
        w_d_stall   = 1'b0;
        w_d_bubble  = 1'b0;
        w_e_bubble  = 1'b0;
        w_m_bubble  = 1'b0;
        w_w_stall   = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_RUN: begin
                    w_f_stall  = w_load_use | w_ret_busy;
                    w_d_stall  = w_load_use;
                    w_d_bubble = w_mispred | (w_ret_busy & !w_load_use);
                    w_e_bubble = w_mispred | w_load_use;
                    w_m_bubble = w_m_exc | w_w_exc;
                    w_w_stall  = w_w_exc;
                    if (w_w_exc) begin
                        w_state_nxt = ST_STOP;
                    end else if (w_m_exc) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    w_f_stall  = 1'b1;
                    w_d_bubble = 1'b1;
                    w_e_bubble = 1'b1;
                    w_m_bubble = 1'b1;
                    if (w_w_exc) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
                ST_STOP: begin
                    w_f_stall   = 1'b1;
                    w_d_stall   = 1'b1;
                    w_m_bubble  = 1'b1;
                    w_w_stall   = 1'b1;
                    w_state_nxt = ST_STOP;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end else begin
            w_state_nxt = ST_RUN;
        end
    end

    // FSM state, architectural status and ret-hold counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_status  <= 3'd1;
            r_ret_cnt <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state != ST_STOP) && w_w_exc) begin
                r_status <= exc_status(bus.w_hlt, bus.w_in_mem, bus.w_in_inst);
            end else begin
                r_status <= r_status;
            end
            if (w_ret_d && !w_load_use && !w_mispred && (r_state == ST_RUN)) begin
                r_ret_cnt <= RET_LOAD;
            end else if (r_ret_cnt != 3'd0) begin
                r_ret_cnt <= r_ret_cnt - 3'd1;
            end else begin
                r_ret_cnt <= r_ret_cnt;
            end
        end
    end

    // Performance counters; the history starts full because the pipe comes out of reset holding bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_cnt  <= '0;
            r_bub_cnt  <= '0;
            r_ret_perf <= '0;
            r_bub_hist <= 3'b111;
        end else begin
            r_bub_hist <= {r_bub_hist[1:0], w_e_bubble};
            if (r_state != ST_STOP) begin
                r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
                if (w_e_bubble) begin
                    r_bub_cnt <= r_bub_cnt + CNT_W'(1);
                end else begin
                    r_bub_cnt <= r_bub_cnt;
                end
                if (!w_w_stall && !r_bub_hist[2]) begin
                    r_ret_perf <= r_ret_perf + CNT_W'(1);
                end else begin
                    r_ret_perf <= r_ret_perf;
                end
            end else begin
                r_cyc_cnt  <= r_cyc_cnt;
                r_bub_cnt  <= r_bub_cnt;
                r_ret_perf <= r_ret_perf;
            end
        end
    end

    assign bus.f_stall      = w_f_stall;
    assign bus.d_stall      = w_d_stall;
    assign bus.d_bubble     = w_d_bubble;
    assign bus.e_bubble     = w_e_bubble;
    assign bus.m_bubble     = w_m_bubble;
    assign bus.w_stall      = w_w_stall;
    assign bus.status       = r_status;
    assign bus.halted       = (r_state == ST_STOP);
    assign bus.cyc_cnt      = r_cyc_cnt;
    assign bus.bub_cnt      = r_bub_cnt;
    assign bus.ret_cnt_perf = r_ret_perf;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl: a behavioural model checked every cycle,
// plus hand-computed literal expectations for each hazard and exception scenario.
module tb_pipe_ctrl;
    localparam int RB = 3;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CW)) bus ();
    pipe_ctrl #(.RET_BUBBLES(RB), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    // Model state: mode 0=RUN 1=DRAIN 2=STOP
    int          md_mode = 0;
    int          md_ret_left = 0;
    logic [2:0]  md_status = 3'd1;
    logic [CW-1:0] md_cyc = '0;
    logic [CW-1:0] md_bub = '0;
    logic [CW-1:0] md_ret = '0;
    logic [2:0]  md_hist = 3'b111;
    bit          md_valid = 1'b0;

    typedef struct packed {
        logic f, ds, db, eb, mb, ws;
        logic lu, mp, rd, me, we;
    } ctl_t;

    function automatic ctl_t model_ctl();
        ctl_t c;
        logic rb;
        c = '0;
        c.lu = ((bus.e_icode == 4'h5) || (bus.e_icode == 4'hB)) && (bus.e_dstM != 4'hF) &&
               ((bus.e_dstM == bus.d_srcA) || (bus.e_dstM == bus.d_srcB));
        c.mp = (bus.e_icode == 4'h7) && (bus.e_cond == 1'b0);
        c.rd = (bus.d_icode == 4'h9);
        c.me = bus.m_hlt || bus.m_in_mem || bus.m_in_inst;
        c.we = bus.w_hlt || bus.w_in_mem || bus.w_in_inst;
        rb   = (c.rd && !c.mp) || (md_ret_left > 0);
        if (rst !== 1'b0) begin
            return c;
        end
        if (md_mode == 0) begin
            c.f  = c.lu || rb;
            c.ds = c.lu;
            c.db = c.mp || (rb && !c.lu);
            c.eb = c.mp || c.lu;
            c.mb = c.me || c.we;
            c.ws = c.we;
        end else if (md_mode == 1) begin
            c.f = 1'b1; c.db = 1'b1; c.eb = 1'b1; c.mb = 1'b1;
        end else begin
            c.f = 1'b1; c.ds = 1'b1; c.mb = 1'b1; c.ws = 1'b1;
        end
        return c;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        ctl_t e;
        e = model_ctl();
        chk1("f_stall", bus.f_stall, e.f);
        chk1("d_stall", bus.d_stall, e.ds);
        chk1("d_bubble", bus.d_bubble, e.db);
        chk1("e_bubble", bus.e_bubble, e.eb);
        chk1("m_bubble", bus.m_bubble, e.mb);
        chk1("w_stall", bus.w_stall, e.ws);
        if (md_valid) begin
            chkn("status", 32'(bus.status), 32'(md_status));
            chk1("halted", bus.halted, (md_mode == 2));
            chkn("cyc_cnt", 32'(bus.cyc_cnt), 32'(md_cyc));
            chkn("bub_cnt", 32'(bus.bub_cnt), 32'(md_bub));
            chkn("ret_cnt_perf", 32'(bus.ret_cnt_perf), 32'(md_ret));
        end
    end

    // Model advance on the clock edge.
    always @(posedge clk) begin
        ctl_t c;
        c = model_ctl();
        if (rst) begin
            md_mode     <= 0;
            md_ret_left <= 0;
            md_status   <= 3'd1;
            md_cyc      <= '0;
            md_bub      <= '0;
            md_ret      <= '0;
            md_hist     <= 3'b111;
            md_valid    <= 1'b1;
        end else begin
            md_hist <= {md_hist[1:0], c.eb};
            if (md_mode != 2) begin
                md_cyc <= md_cyc + CW'(1);
                if (c.eb) md_bub <= md_bub + CW'(1);
                if (!c.ws && !md_hist[2]) md_ret <= md_ret + CW'(1);
            end
            if (c.rd && !c.lu && !c.mp && md_mode == 0) md_ret_left <= RB - 1;
            else if (md_ret_left > 0) md_ret_left <= md_ret_left - 1;
            if (md_mode != 2 && c.we) begin
                md_mode   <= 2;
                md_status <= bus.w_hlt ? 3'd2 : (bus.w_in_mem ? 3'd3 : 3'd4);
            end else if (md_mode == 0 && c.me) begin
                md_mode <= 1;
            end
        end
    end

    task automatic setv(input logic [3:0] di, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] ei, input logic [3:0] edm, input logic ec,
                        input logic [2:0] mf, input logic [2:0] wf);
        bus.d_icode = di; bus.d_srcA = sa; bus.d_srcB = sb;
        bus.e_icode = ei; bus.e_dstM = edm; bus.e_cond = ec;
        {bus.m_hlt, bus.m_in_mem, bus.m_in_inst} = mf;
        {bus.w_hlt, bus.w_in_mem, bus.w_in_inst} = wf;
    endtask

    task automatic nop_in();
        setv(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 3'b000, 3'b000);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; nop_in(); tick(); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        nop_in();
        tick(); tick();
        rst = 1'b0;
        at_neg();
        chkn("rst_status", 32'(bus.status), 32'd1);
        chk1("rst_halted", bus.halted, 1'b0);
        chkn("rst_cyc", 32'(bus.cyc_cnt), 32'd0);
        tick();

        // Load-use on srcA, then clear
        setv(4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 3'b000, 3'b000);
        at_neg();
        chk1("lu_f", bus.f_stall, 1'b1); chk1("lu_ds", bus.d_stall, 1'b1);
        chk1("lu_eb", bus.e_bubble, 1'b1); chk1("lu_db", bus.d_bubble, 1'b0);
        tick(); nop_in(); at_neg();
        chk1("lu_clr_f", bus.f_stall, 1'b0); chk1("lu_clr_ds", bus.d_stall, 1'b0);
        chk1("lu_clr_eb", bus.e_bubble, 1'b0);
        tick();

        // dstM = F never hazards; popq against srcB does
        setv(4'h1, 4'hF, 4'hF, 4'h5, 4'hF, 1'b1, 3'b000, 3'b000);
        at_neg(); chk1("nolu_ds", bus.d_stall, 1'b0); tick();
        setv(4'h1, 4'hF, 4'h2, 4'hB, 4'h2, 1'b1, 3'b000, 3'b000);
        at_neg(); chk1("pop_srcB_ds", bus.d_stall, 1'b1); tick();

        // Ret: exactly RB cycles of fetch hold
        setv(4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 3'b000, 3'b000);
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk1("ret_f", bus.f_stall, (i < RB));
            chk1("ret_db", bus.d_bubble, (i < RB));
            tick(); nop_in();
        end

        // Mispredict squashes the ret in D
        setv(4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 3'b000, 3'b000);
        at_neg();
        chk1("mp_db", bus.d_bubble, 1'b1); chk1("mp_eb", bus.e_bubble, 1'b1);
        chk1("mp_f", bus.f_stall, 1'b0);
        tick(); nop_in();
        for (int i = 0; i < 3; i++) begin
            at_neg(); chk1("mp_noret_f", bus.f_stall, 1'b0); tick();
        end

        // Ret waiting behind load-use
        setv(4'h9, 4'h4, 4'hF, 4'hB, 4'h4, 1'b1, 3'b000, 3'b000);
        at_neg();
        chk1("rlu_ds", bus.d_stall, 1'b1); chk1("rlu_db", bus.d_bubble, 1'b0);
        chk1("rlu_f", bus.f_stall, 1'b1); chk1("rlu_eb", bus.e_bubble, 1'b1);
        tick();
        setv(4'h9, 4'h4, 4'hF, 4'h0, 4'hF, 1'b1, 3'b000, 3'b000);
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk1("rlu_ret_f", bus.f_stall, (i < RB));
            chk1("rlu_ret_db", bus.d_bubble, (i < RB));
            chk1("rlu_ret_ds", bus.d_stall, 1'b0);
            tick(); nop_in();
        end

        // Taken jXX: no bubbles
        setv(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 3'b000, 3'b000);
        at_neg(); chk1("jtaken_eb", bus.e_bubble, 1'b0); chk1("jtaken_db", bus.d_bubble, 1'b0);
        tick();

        // Controls forced low during reset even with a hazard present
        rst = 1'b1;
        setv(4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 3'b100, 3'b100);
        at_neg(); chk1("inrst_f", bus.f_stall, 1'b0); chk1("inrst_eb", bus.e_bubble, 1'b0);
        chk1("inrst_ws", bus.w_stall, 1'b0);
        tick(); rst = 1'b0; nop_in();

        // cyc_cnt wraps 15 -> 0 with a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            at_neg();
            if (i == 15) chkn("cyc_15", 32'(bus.cyc_cnt), 32'd15);
            if (i == 16) chkn("cyc_wrap", 32'(bus.cyc_cnt), 32'd0);
            tick();
        end

        // Halt drain then stop
        setv(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 3'b100, 3'b000);
        at_neg(); chk1("hm_mb", bus.m_bubble, 1'b1); chk1("hm_halted", bus.halted, 1'b0);
        tick();
        setv(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 3'b000, 3'b100);
        at_neg();
        chk1("dr_f", bus.f_stall, 1'b1); chk1("dr_db", bus.d_bubble, 1'b1);
        chk1("dr_eb", bus.e_bubble, 1'b1); chk1("dr_mb", bus.m_bubble, 1'b1);
        chk1("dr_ws", bus.w_stall, 1'b0); chk1("dr_ds", bus.d_stall, 1'b0);
        chk1("dr_halted", bus.halted, 1'b0);
        tick(); nop_in();
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk1("stop_halted", bus.halted, 1'b1);
            chkn("stop_status", 32'(bus.status), 32'd2);
            chk1("stop_ws", bus.w_stall, 1'b1); chk1("stop_ds", bus.d_stall, 1'b1);
            tick();
        end
        do_reset();
        at_neg();
        chkn("post_rst_status", 32'(bus.status), 32'd1);
        chk1("post_rst_halted", bus.halted, 1'b0);
        tick();

        // Reset in the middle of a drain returns to RUN
        setv(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 3'b010, 3'b000);
        tick(); nop_in();
        at_neg(); chk1("mid_dr_eb", bus.e_bubble, 1'b1); tick();
        do_reset();
        at_neg(); chk1("mid_rst_db", bus.d_bubble, 1'b0); chk1("mid_rst_f", bus.f_stall, 1'b0);
        tick();

        // Simultaneous m_in_inst and w_in_mem: straight to STOP with ADR
        setv(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 3'b001, 3'b010);
        at_neg(); chk1("sim_ws", bus.w_stall, 1'b1); chk1("sim_mb", bus.m_bubble, 1'b1);
        tick(); nop_in();
        at_neg(); chk1("sim_halted", bus.halted, 1'b1);
        chkn("sim_status", 32'(bus.status), 32'd3);
        tick(); tick();

        // Status priority: hlt over in_mem, and in_inst alone
        do_reset();
        setv(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 3'b000, 3'b110);
        tick(); nop_in();
        at_neg(); chkn("prio_hlt", 32'(bus.status), 32'd2); tick();
        do_reset();
        setv(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 3'b000, 3'b001);
        tick(); nop_in();
        at_neg(); chkn("prio_ins", 32'(bus.status), 32'd4); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
